alarm_trigger: RTL and testbench
================================

ALARM_TRIGGER -- requirements
Module: alarm_trigger

Interface
REQ-001 Parameter RING_LIMIT, default 60: number of tick_1hz pulses a ring period lasts before auto-stop.
REQ-002 Parameter SNOOZE_SEC, default 300: number of tick_1hz pulses in one snooze interval.
REQ-003 Parameter MAX_SNOOZE, default 3: maximum snoozes per alarm event.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick_1hz  input  1  one-clk-wide pulse, once per second.
REQ-007 cur_hour  input  5  current hour, 0-23; cur_min  input  6  current minute, 0-59.
REQ-008 alarm_hour  input  5  alarm hour; alarm_min  input  6  alarm minute.
REQ-009 alarm_en  input  1  level; 1 = alarm armed.
REQ-010 snooze_btn  input  1  debounced one-clk pulse; stop_btn  input  1  debounced one-clk pulse.
REQ-011 alram_sound  output  1  registered; 1 = sound stage shall play.
REQ-012 alarm_pending  output  1  registered; 1 = state is RINGING or SNOOZE.
REQ-013 snooze_cnt  output  2  registered; snoozes used in current alarm event.

Function
REQ-014 match = (cur_hour==alarm_hour) && (cur_min==alarm_min); match_d = match registered one clk.
REQ-015 trigger = alarm_en && match && !match_d; enabling alarm_en while match already 1 shall not trigger.
REQ-016 FSM states: IDLE, RINGING, SNOOZE; alram_sound = (state==RINGING), alarm_pending = (state!=IDLE), both registered with state.
REQ-017 IDLE: trigger -> RINGING at next edge; ring_cnt=0, snooze_cnt=0; alram_sound high from that edge (1-clk latency from trigger cycle).
REQ-018 RINGING: each tick_1hz increments ring_cnt; tick_1hz with ring_cnt==RING_LIMIT-1 -> IDLE (auto-stop).
REQ-019 RINGING: snooze_btn with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, snz_cnt=0.
REQ-020 RINGING: snooze_btn with snooze_cnt==MAX_SNOOZE ignored; ringing continues, ring_cnt unaffected.
REQ-021 SNOOZE: each tick_1hz increments snz_cnt; tick_1hz with snz_cnt==SNOOZE_SEC-1 -> RINGING, ring_cnt=0.
REQ-022 SNOOZE: snooze_btn ignored.
REQ-023 RINGING or SNOOZE: stop_btn -> IDLE; alarm_en==0 -> IDLE; snooze_cnt holds until next trigger.
REQ-024 Same-cycle priority: alarm_en==0 > stop_btn > snooze_btn > tick_1hz expiry/increment.
REQ-025 trigger while RINGING or SNOOZE ignored (no counter restart).
REQ-026 Counters sized from parameters ($clog2), never wrap: reset at state entry only.
REQ-027 After stop/auto-stop within the alarm minute, no retrigger until match falls and rises again.

Reset
REQ-028 reset=1 forces immediately, regardless of clk: state=IDLE, alram_sound=0, alarm_pending=0, snooze_cnt=0, ring_cnt=0, snz_cnt=0, match_d=1.
REQ-029 match_d resetting to 1 means a time already matching at reset release shall not ring.
REQ-030 reset asserted mid-RINGING/SNOOZE aborts the event; alram_sound low within the same cycle.

Verification (RING_LIMIT=4, SNOOZE_SEC=3, MAX_SNOOZE=2 overrides allowed)
REQ-031 alarm 07:30, en=1, cur 07:29 -> 07:30 -> alram_sound=1 one clk after change; 4 ticks later alram_sound=0, state IDLE.
REQ-032 ringing, snooze_btn -> alram_sound=0, snooze_cnt=1, alarm_pending=1; 3 ticks later alram_sound=1.
REQ-033 snooze twice, third snooze_btn while ringing -> ignored, snooze_cnt=2, alram_sound stays 1.
REQ-034 stop_btn and snooze_btn same cycle while ringing -> IDLE, snooze_cnt unchanged; cur_min stays 30 -> no retrigger.
REQ-035 en=0 at match, en 0->1 inside matching minute -> no ring; en=0 during SNOOZE -> IDLE.
REQ-036 reset pulse between clk edges while ringing -> alram_sound=0 immediately; release with cur==alarm time -> stays IDLE.

Source files
------------

// File: rtl/alarm_trigger.sv
// ============================================================================
// Module   : alarm_trigger
// Purpose  : Alarm-clock ring/snooze/stop controller driven by a 1 Hz tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_trigger #(
    parameter int RING_LIMIT = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       alram_sound,
    output logic       alarm_pending,
    output logic [1:0] snooze_cnt
);

    localparam int RC_W = (RING_LIMIT > 1) ? $clog2(RING_LIMIT) : 1;
    localparam int SC_W = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_LIMIT - 1);
    localparam logic [SC_W-1:0] SNZ_LAST  = SC_W'(SNOOZE_SEC - 1);
    localparam logic [1:0]      SNZ_MAX   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    state_t          state;
    logic [RC_W-1:0] ring_cnt;
    logic [SC_W-1:0] snz_cnt;
    logic            match_d;
    logic            match;
    logic            trigger;

    assign match   = (cur_hour == alarm_hour) && (cur_min == alarm_min);
    // Rising edge of match only, so stopping inside the alarm minute never re-rings.
    assign trigger = alarm_en && match && !match_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            alram_sound   <= 1'b0;
            alarm_pending <= 1'b0;
            snooze_cnt    <= 2'd0;
            ring_cnt      <= '0;
            snz_cnt       <= '0;
            match_d       <= 1'b1;
        end else begin
            match_d <= match;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state         <= RINGING;
                        alram_sound   <= 1'b1;
                        alarm_pending <= 1'b1;
                        ring_cnt      <= '0;
                        snooze_cnt    <= 2'd0;
                    end
                end
                RINGING: begin
                    if (!alarm_en || stop_btn) begin
                        state         <= IDLE;
                        alram_sound   <= 1'b0;
                        alarm_pending <= 1'b0;
                    end else if (snooze_btn && (snooze_cnt < SNZ_MAX)) begin
                        state       <= SNOOZE;
                        alram_sound <= 1'b0;
                        snooze_cnt  <= snooze_cnt + 2'd1;
                        snz_cnt     <= '0;
                    end else if (tick_1hz) begin
                        if (ring_cnt == RING_LAST) begin
                            state         <= IDLE;
                            alram_sound   <= 1'b0;
                            alarm_pending <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (!alarm_en || stop_btn) begin
                        state         <= IDLE;
                        alram_sound   <= 1'b0;
                        alarm_pending <= 1'b0;
                    end else if (tick_1hz) begin
                        if (snz_cnt == SNZ_LAST) begin
                            state       <= RINGING;
                            alram_sound <= 1'b1;
                            ring_cnt    <= '0;
                        end else begin
                            snz_cnt <= snz_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    alram_sound   <= 1'b0;
                    alarm_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alarm_trigger.sv
// ============================================================================
// Module   : tb_alarm_trigger
// Purpose  : Scoreboard bench for alarm_trigger (RING_LIMIT=4, SNOOZE_SEC=3, MAX_SNOOZE=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_trigger;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_en;
    logic       snooze_btn;
    logic       stop_btn;
    logic       alram_sound;
    logic       alarm_pending;
    logic [1:0] snooze_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Each entry is {alram_sound, alarm_pending, snooze_cnt}.
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    alarm_trigger #(
        .RING_LIMIT(4),
        .SNOOZE_SEC(3),
        .MAX_SNOOZE(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1hz     (tick_1hz),
        .cur_hour     (cur_hour),
        .cur_min      (cur_min),
        .alarm_hour   (alarm_hour),
        .alarm_min    (alarm_min),
        .alarm_en     (alarm_en),
        .snooze_btn   (snooze_btn),
        .stop_btn     (stop_btn),
        .alram_sound  (alram_sound),
        .alarm_pending(alarm_pending),
        .snooze_cnt   (snooze_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // One clock of stimulus: expectation goes in when driven, DUT state comes out after the edge.
    task automatic cyc(input logic tk, input logic sn, input logic st, input logic [3:0] exp);
        tick_1hz   = tk;
        snooze_btn = sn;
        stop_btn   = st;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        obs_q.push_back({alram_sound, alarm_pending, snooze_cnt});
        tick_1hz   = 1'b0;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
    endtask

    // Move time 07:29 -> 07:30; prev is the idle snooze_cnt still held from the last event.
    task automatic arm(input logic [1:0] prev);
        cur_min = 6'd29;
        cyc(1'b0, 1'b0, 1'b0, {2'b00, prev});
        cur_min = 6'd30;
        cyc(1'b0, 1'b0, 1'b0, 4'b1100);
    endtask

    task automatic test_reset;
        logic [3:0] e, o;
        int n = 0;
        reset      = 1'b1;
        tick_1hz   = 1'b0;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        alarm_en   = 1'b1;
        alarm_hour = 5'd7;
        alarm_min  = 6'd30;
        cur_hour   = 5'd7;
        cur_min    = 6'd30;
        #12;
        vectors++;
        if ({alram_sound, alarm_pending, snooze_cnt} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: got %b want 0000", {alram_sound, alarm_pending, snooze_cnt});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 4'b0000);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_release_match step %0d: got %b want %b", n, o, e);
            end
        end
    endtask

    task automatic test_ring_autostop;
        logic [3:0] e, o;
        int n = 0;
        arm(2'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 4'b1100);
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        cyc(1'b0, 1'b0, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, 1'b0, 4'b0000);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL ring_autostop step %0d: got %b want %b", n, o, e);
            end
        end
    endtask

    task automatic test_snooze;
        logic [3:0] e, o;
        int n = 0;
        arm(2'd0);
        cyc(1'b0, 1'b1, 1'b0, 4'b0101);
        cyc(1'b0, 1'b1, 1'b0, 4'b0101);
        cyc(1'b1, 1'b0, 1'b0, 4'b0101);
        cyc(1'b1, 1'b0, 1'b0, 4'b0101);
        cyc(1'b1, 1'b0, 1'b0, 4'b1101);
        cyc(1'b0, 1'b0, 1'b1, 4'b0001);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL snooze step %0d: got %b want %b", n, o, e);
            end
        end
    endtask

    task automatic test_snooze_limit;
        logic [3:0] e, o;
        int n = 0;
        arm(2'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'b0101);
        cyc(1'b1, 1'b0, 1'b0, 4'b0101);
        cyc(1'b1, 1'b0, 1'b0, 4'b0101);
        cyc(1'b1, 1'b0, 1'b0, 4'b1101);
        cyc(1'b0, 1'b1, 1'b0, 4'b0110);
        cyc(1'b1, 1'b0, 1'b0, 4'b0110);
        cyc(1'b1, 1'b0, 1'b0, 4'b0110);
        cyc(1'b1, 1'b0, 1'b0, 4'b1110);
        cyc(1'b1, 1'b0, 1'b0, 4'b1110);
        cyc(1'b0, 1'b1, 1'b0, 4'b1110);
        cyc(1'b1, 1'b0, 1'b0, 4'b1110);
        cyc(1'b1, 1'b0, 1'b0, 4'b1110);
        cyc(1'b1, 1'b0, 1'b0, 4'b0010);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL snooze_limit step %0d: got %b want %b", n, o, e);
            end
        end
    endtask

    task automatic test_stop_priority;
        logic [3:0] e, o;
        int n = 0;
        arm(2'd2);
        cyc(1'b0, 1'b1, 1'b0, 4'b0101);
        cyc(1'b1, 1'b0, 1'b0, 4'b0101);
        cyc(1'b1, 1'b0, 1'b0, 4'b0101);
        cyc(1'b1, 1'b0, 1'b0, 4'b1101);
        cyc(1'b0, 1'b1, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 4'b0001);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL stop_priority step %0d: got %b want %b", n, o, e);
            end
        end
    endtask

    task automatic test_enable;
        logic [3:0] e, o;
        int n = 0;
        alarm_en = 1'b0;
        cur_min  = 6'd29;
        cyc(1'b0, 1'b0, 1'b0, 4'b0001);
        cur_min = 6'd30;
        cyc(1'b0, 1'b0, 1'b0, 4'b0001);
        alarm_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'b0001);
        cyc(1'b0, 1'b0, 1'b0, 4'b0001);
        arm(2'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'b0101);
        alarm_en = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 4'b0001);
        alarm_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'b0001);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL enable step %0d: got %b want %b", n, o, e);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] e, o;
        int n = 0;
        arm(2'd1);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({alram_sound, alarm_pending, snooze_cnt} !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset_mid_ring: got %b want 0000", {alram_sound, alarm_pending, snooze_cnt});
        end
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 4'b0000);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL async_reset_release step %0d: got %b want %b", n, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ring_autostop();
        test_snooze();
        test_snooze_limit();
        test_stop_priority();
        test_enable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
